// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// Signal names keep the arbiter-side direction suffixes (_i into the arbiter, _o out of it).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Core load/store path
    logic              core_req_i;
    logic              core_we_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [DATA_W-1:0] core_wdata_i;
    logic [BE_W-1:0]   core_be_i;
    logic              core_gnt_o;
    logic              core_rvalid_o;
    logic [DATA_W-1:0] core_rdata_o;

    // External port (loader / debug DMA)
    logic              ext_req_i;
    logic              ext_we_i;
    logic [ADDR_W-1:0] ext_addr_i;
    logic [DATA_W-1:0] ext_wdata_i;
    logic [BE_W-1:0]   ext_be_i;
    logic              ext_lock_i;
    logic              ext_gnt_o;
    logic              ext_rvalid_o;
    logic [DATA_W-1:0] ext_rdata_o;

    // Memory side
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter view
    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i, ext_lock_i,
        output ext_gnt_o, ext_rvalid_o, ext_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    // Requester + memory view (the system around the arbiter)
    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i, ext_lock_i,
        input  ext_gnt_o, ext_rvalid_o, ext_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory between the core LSU and an external
// port. Combinational grant, one-cycle read return, and a capped exclusive lock
// for the external port so the core is never starved.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    dmem_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_ARB      = 1'b0;
    localparam logic [0:0] ST_EXT_LOCK = 1'b1;
    localparam logic [7:0] MAX_CNT     = 8'(MAX_BURST);

    logic [0:0] r_state;
    logic       r_prio;       // 0: core wins a tie, 1: external port wins
    logic [7:0] r_burst_cnt;
    logic       r_rd_core;
    logic       r_rd_ext;

    logic       w_core_gnt;
    logic       w_ext_gnt;
    logic       w_sat;

    // Lock age counter never exceeds the cap
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt >= MAX_CNT) ? MAX_CNT : cnt + 8'd1;
    endfunction

    assign w_sat = (r_burst_cnt == MAX_CNT);

    // Grant decision; nothing is granted while reset is asserted
    always_comb begin
        w_core_gnt = 1'b0;
        w_ext_gnt  = 1'b0;
        if (!reset_i) begin
            if (r_state == ST_ARB) begin
                if (bus.core_req_i && bus.ext_req_i) begin
                    w_ext_gnt  = r_prio;
                    w_core_gnt = ~r_prio;
                end else begin
                    w_core_gnt = bus.core_req_i;
                    w_ext_gnt  = bus.ext_req_i;
                end
            end else begin
                // A lock release in the same cycle keeps the memory with the
                // external port; only a still-held, saturated lock yields.
                if (bus.ext_lock_i && w_sat && bus.core_req_i) begin
                    w_core_gnt = 1'b1;
                end else begin
                    w_ext_gnt = bus.ext_req_i;
                end
            end
        end
    end

    // Arbitration state: lock tracking, burst counter and tie priority
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_ARB;
            r_prio      <= 1'b0;
            r_burst_cnt <= 8'd0;
        end else if (r_state == ST_ARB) begin
            if (w_core_gnt && bus.ext_req_i) begin
                r_prio <= 1'b1;
            end else if (w_ext_gnt && bus.core_req_i) begin
                r_prio <= 1'b0;
            end
            if (w_ext_gnt && bus.ext_lock_i) begin
                r_state     <= ST_EXT_LOCK;
                r_burst_cnt <= 8'd1;
            end
        end else begin
            if (!bus.ext_lock_i) begin
                r_state     <= ST_ARB;
                r_burst_cnt <= 8'd0;
            end else if (w_core_gnt) begin
                r_state     <= ST_ARB;
                r_prio      <= 1'b1;
                r_burst_cnt <= 8'd0;
            end else begin
                r_burst_cnt <= sat_inc(r_burst_cnt);
            end
        end
    end

    // Remember which requester owns the read data arriving next cycle
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_core <= 1'b0;
            r_rd_ext  <= 1'b0;
        end else begin
            r_rd_core <= w_core_gnt & ~bus.core_we_i;
            r_rd_ext  <= w_ext_gnt & ~bus.ext_we_i;
        end
    end

    // Steer the granted requester onto the memory; idle bus is all zeros
    always_comb begin
        bus.mem_en_o    = w_core_gnt | w_ext_gnt;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_be_o    = '0;
        if (w_core_gnt) begin
            bus.mem_we_o    = bus.core_we_i;
            bus.mem_addr_o  = bus.core_addr_i;
            bus.mem_wdata_o = bus.core_wdata_i;
            bus.mem_be_o    = bus.core_be_i;
        end else if (w_ext_gnt) begin
            bus.mem_we_o    = bus.ext_we_i;
            bus.mem_addr_o  = bus.ext_addr_i;
            bus.mem_wdata_o = bus.ext_wdata_i;
            bus.mem_be_o    = bus.ext_be_i;
        end
    end

    assign bus.core_gnt_o    = w_core_gnt;
    assign bus.ext_gnt_o     = w_ext_gnt;
    assign bus.core_rvalid_o = r_rd_core;
    assign bus.ext_rvalid_o  = r_rd_ext;
    assign bus.core_rdata_o  = r_rd_core ? bus.mem_rdata_i : '0;
    assign bus.ext_rdata_o   = r_rd_ext  ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a word memory behind the arbiter plus a
// transaction-level reference of who should own the memory each cycle.
module tb_dmem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks = 0;
    int passes = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Memory behind the arbiter: reloaded during reset, junk on idle read cycles
    logic [31:0] tbmem [0:15];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) tbmem[i] <= init_word(i);
            bus.mem_rdata_i <= $urandom;
        end else begin
            if (bus.mem_en_o && !bus.mem_we_o) bus.mem_rdata_i <= tbmem[bus.mem_addr_o[5:2]];
            else                               bus.mem_rdata_i <= $urandom;
            if (bus.mem_en_o && bus.mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be_o[b]) tbmem[bus.mem_addr_o[5:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
        end
    end

    // Reference model state
    bit          m_lock;
    int          m_cnt;
    bit          m_prio;
    bit          m_rd_core, m_rd_ext;
    logic [31:0] m_core_data, m_ext_data;
    logic [31:0] gm [0:15];
    int          m_g;          // 0 none, 1 core, 2 ext
    logic [137:0] exp_v;

    function automatic logic [137:0] obs();
        return {bus.core_gnt_o, bus.ext_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o,
                bus.mem_wdata_o, bus.mem_be_o, bus.core_rvalid_o, bus.core_rdata_o,
                bus.ext_rvalid_o, bus.ext_rdata_o};
    endfunction

    task automatic model_reset();
        m_lock = 0; m_cnt = 0; m_prio = 0; m_rd_core = 0; m_rd_ext = 0; m_g = 0;
        m_core_data = '0; m_ext_data = '0;
        for (int i = 0; i < 16; i++) gm[i] = init_word(i);
    endtask

    task automatic model_eval();
        logic        we;
        logic [31:0] a, wd;
        logic [3:0]  be;
        m_g = 0;
        if (!rst) begin
            if (!m_lock) begin
                if (bus.core_req_i && bus.ext_req_i) m_g = m_prio ? 2 : 1;
                else if (bus.core_req_i)             m_g = 1;
                else if (bus.ext_req_i)              m_g = 2;
            end else if (bus.ext_lock_i && m_cnt == MAXB && bus.core_req_i) begin
                m_g = 1;
            end else if (bus.ext_req_i) begin
                m_g = 2;
            end
        end
        we = 0; a = '0; wd = '0; be = '0;
        if (m_g == 1) begin we = bus.core_we_i; a = bus.core_addr_i; wd = bus.core_wdata_i; be = bus.core_be_i; end
        if (m_g == 2) begin we = bus.ext_we_i;  a = bus.ext_addr_i;  wd = bus.ext_wdata_i;  be = bus.ext_be_i;  end
        exp_v = {m_g == 1, m_g == 2, m_g != 0, we, a, wd, be,
                 m_rd_core, m_rd_core ? m_core_data : 32'h0,
                 m_rd_ext,  m_rd_ext  ? m_ext_data  : 32'h0};
    endtask

    task automatic model_update();
        logic        we;
        logic [31:0] a, wd;
        logic [3:0]  be;
        if (!m_lock) begin
            if (bus.core_req_i && bus.ext_req_i) m_prio = (m_g == 1);
            if (m_g == 2 && bus.ext_lock_i) begin m_lock = 1; m_cnt = 1; end
        end else begin
            if (!bus.ext_lock_i)  begin m_lock = 0; m_cnt = 0; end
            else if (m_g == 1)    begin m_lock = 0; m_prio = 1; m_cnt = 0; end
            else if (m_cnt < MAXB) m_cnt = m_cnt + 1;
        end
        m_rd_core = (m_g == 1) && !bus.core_we_i;
        m_rd_ext  = (m_g == 2) && !bus.ext_we_i;
        if (m_rd_core) m_core_data = gm[bus.core_addr_i[5:2]];
        if (m_rd_ext)  m_ext_data  = gm[bus.ext_addr_i[5:2]];
        we = 0; a = '0; wd = '0; be = '0;
        if (m_g == 1) begin we = bus.core_we_i; a = bus.core_addr_i; wd = bus.core_wdata_i; be = bus.core_be_i; end
        if (m_g == 2) begin we = bus.ext_we_i;  a = bus.ext_addr_i;  wd = bus.ext_wdata_i;  be = bus.ext_be_i;  end
        if (m_g != 0 && we)
            for (int b = 0; b < 4; b++) if (be[b]) gm[a[5:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.core_req_i = 0; bus.core_we_i = 0; bus.core_addr_i = '0; bus.core_wdata_i = '0; bus.core_be_i = '0;
        bus.ext_req_i = 0;  bus.ext_we_i = 0;  bus.ext_addr_i = '0;  bus.ext_wdata_i = '0;  bus.ext_be_i = '0;
        bus.ext_lock_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        model_reset();
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        model_reset();
        bus.core_req_i = 1; bus.core_addr_i = 32'h10; bus.core_we_i = 1; bus.core_be_i = 4'hF;
        bus.ext_req_i = 1;  bus.ext_addr_i = 32'h14;  bus.ext_lock_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL reset_outputs cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            checks++;
            if ({bus.mem_en_o, bus.mem_we_o} !== 2'b00)
                $display("FAIL reset_mem_en cyc %0d: got %b expected 00", i, {bus.mem_en_o, bus.mem_we_o});
            else passes++;
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_core_read();
        do_reset();
        bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 32'h10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL core_read cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            if (i == 1) begin
                checks++;
                if ({bus.core_rvalid_o, bus.core_rdata_o, bus.ext_rvalid_o} !== {1'b1, 32'hDEADBEEF, 1'b0})
                    $display("FAIL core_read_data: got %b/%h/%b expected 1/deadbeef/0",
                             bus.core_rvalid_o, bus.core_rdata_o, bus.ext_rvalid_o);
                else passes++;
            end
            tick();
            bus.core_req_i = 0;
        end
    endtask

    task automatic test_tie();
        logic [1:0] want;
        do_reset();
        bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 32'h04;
        bus.ext_req_i  = 1; bus.ext_we_i  = 0; bus.ext_addr_i  = 32'h08;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin bus.core_req_i = 0; bus.ext_req_i = 0; end
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL tie cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            if (i < 4) begin
                want = (i % 2 == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({bus.core_gnt_o, bus.ext_gnt_o} !== want)
                    $display("FAIL tie_alternate cyc %0d: got %b expected %b", i, {bus.core_gnt_o, bus.ext_gnt_o}, want);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_lock_release();
        logic [1:0] want [0:3];
        want[0] = 2'b01; want[1] = 2'b01; want[2] = 2'b01; want[3] = 2'b10;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.ext_req_i   = (i < 3);
            bus.ext_we_i    = 1;
            bus.ext_addr_i  = 32'(4 * (i + 8));
            bus.ext_wdata_i = $urandom;
            bus.ext_be_i    = 4'hF;
            bus.ext_lock_i  = (i < 2);
            bus.core_req_i  = (i > 0);
            bus.core_we_i   = 0;
            bus.core_addr_i = 32'h20;
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL lock_release cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            checks++;
            if ({bus.core_gnt_o, bus.ext_gnt_o} !== want[i])
                $display("FAIL lock_release_gnt cyc %0d: got %b expected %b", i, {bus.core_gnt_o, bus.ext_gnt_o}, want[i]);
            else passes++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock_cap();
        logic [1:0] want;
        do_reset();
        bus.ext_we_i = 1; bus.ext_be_i = 4'h3; bus.ext_lock_i = 1; bus.ext_req_i = 1;
        bus.core_we_i = 0; bus.core_addr_i = 32'h0C;
        for (int i = 0; i < 7; i++) begin
            bus.core_req_i  = (i > 0);
            bus.ext_addr_i  = 32'(4 * (i % 16));
            bus.ext_wdata_i = $urandom;
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL lock_cap cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            want = (i == 4) ? 2'b10 : 2'b01;
            if (i < 6) begin
                checks++;
                if ({bus.core_gnt_o, bus.ext_gnt_o} !== want)
                    $display("FAIL lock_cap_gnt cyc %0d: got %b expected %b", i, {bus.core_gnt_o, bus.ext_gnt_o}, want);
                else passes++;
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 32'h10;
        bus.ext_req_i = 1;  bus.ext_lock_i = 1; bus.ext_addr_i = 32'h18;
        @(negedge clk); model_eval();
        checks++;
        if (obs() !== exp_v) $display("FAIL reset_mid_grant: got %h expected %h", obs(), exp_v);
        else passes++;
        #2 rst = 1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL reset_mid cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            checks++;
            if (bus.core_rvalid_o !== 1'b0) $display("FAIL reset_mid_rvalid cyc %0d: got %b expected 0", i, bus.core_rvalid_o);
            else passes++;
        end
        tick();
        rst = 0;
        clear_inputs();
        // after reset the core must win a tie and no lock may survive
        bus.core_req_i = 1; bus.core_addr_i = 32'h10; bus.ext_req_i = 1; bus.ext_lock_i = 1;
        @(negedge clk); model_eval();
        checks++;
        if ({bus.core_gnt_o, bus.ext_gnt_o} !== 2'b10)
            $display("FAIL reset_mid_after: got %b expected 10", {bus.core_gnt_o, bus.ext_gnt_o});
        else passes++;
        tick();
        clear_inputs();
        @(negedge clk); model_eval();
        tick();
    endtask

    task automatic test_byte_write();
        do_reset();
        bus.core_req_i = 1; bus.core_we_i = 1; bus.core_addr_i = 32'h20;
        bus.core_be_i = 4'b0100; bus.core_wdata_i = 32'h00AB0000;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin bus.core_we_i = 0; bus.core_be_i = 4'h0; end
            if (i == 2) bus.core_req_i = 0;
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL byte_write cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            if (i == 0) begin
                checks++;
                if ({bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o} !== {1'b1, 4'b0100, 32'h00AB0000})
                    $display("FAIL byte_write_bus: got %b/%b/%h expected 1/0100/00ab0000",
                             bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o);
                else passes++;
            end
            if (i == 1) begin
                checks++;
                if (bus.core_rvalid_o !== 1'b0) $display("FAIL byte_write_rvalid: got %b expected 0", bus.core_rvalid_o);
                else passes++;
            end
            if (i == 2) begin
                checks++;
                if (bus.core_rdata_o !== ((init_word(8) & 32'hFF00FFFF) | 32'h00AB0000))
                    $display("FAIL byte_write_readback: got %h expected %h", bus.core_rdata_o,
                             (init_word(8) & 32'hFF00FFFF) | 32'h00AB0000);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_g == 1 || !bus.core_req_i || ($urandom % 16 == 0)) begin
                bus.core_req_i   = ($urandom % 3 != 0);
                bus.core_we_i    = $urandom % 2;
                bus.core_addr_i  = 32'(($urandom % 16) * 4);
                bus.core_wdata_i = $urandom;
                bus.core_be_i    = 4'($urandom % 16);
            end
            if (m_g == 2 || !bus.ext_req_i || ($urandom % 16 == 0)) begin
                bus.ext_req_i   = ($urandom % 3 != 0);
                bus.ext_we_i    = $urandom % 2;
                bus.ext_addr_i  = 32'(($urandom % 16) * 4);
                bus.ext_wdata_i = $urandom;
                bus.ext_be_i    = 4'($urandom % 16);
            end
            bus.ext_lock_i = ($urandom % 4 != 0);
            @(negedge clk); model_eval();
            checks++;
            if (obs() !== exp_v) $display("FAIL random cyc %0d: got %h expected %h", i, obs(), exp_v);
            else passes++;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_core_read();
        test_tie();
        test_lock_release();
        test_lock_cap();
        test_reset_mid();
        test_byte_write();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between the core load/store path and an external port (program loader / debug DMA). Each cycle it grants at most one requester and steers its address, write data and byte enables onto the memory. It returns read data to the requester that issued the read one cycle later. The external port can lock the memory for short bursts, capped so the core is never starved.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and the memory
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_BURST, 8, maximum cycles the external port may hold a lock while the core waits (range 1..255)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- core_req_i  in  1  core access request; held with stable fields until granted
- core_we_i  in  1  1 = write, 0 = read
- core_addr_i  in  ADDR_W  byte address
- core_wdata_i  in  DATA_W  write data (already lane-aligned by LSU)
- core_be_i  in  DATA_W/8  byte enables for writes
- core_gnt_o  out  1  request accepted this cycle
- core_rvalid_o  out  1  read data valid for core
- core_rdata_o  out  DATA_W  read data for core
- ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i  in  same widths as core_*  external port request
- ext_lock_i  in  1  external port requests exclusive ownership
- ext_gnt_o, ext_rvalid_o  out  1  as core_*
- ext_rdata_o  out  DATA_W  as core_rdata_o
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_rdata_i  in  DATA_W  memory read data, valid one cycle after a read enable

## Operation
State:
- state_q: ARB or EXT_LOCK
- prio_q: 0 = core wins a tie, 1 = external port wins
- burst_cnt_q: counts cycles in EXT_LOCK, saturates at MAX_BURST
- rd_core_q, rd_ext_q: registered read-outstanding flags

Grants:
- Grants are combinational from the requests and the current state.
- At most one grant is asserted per cycle.
- mem_en_o = core_gnt_o | ext_gnt_o.
- mem_we/addr/wdata/be are muxed from the granted requester, and are 0 when neither is granted.

ARB state:
- If exactly one requester is requesting, grant it.
- If both are requesting, grant the one selected by prio_q, then set prio_q to the loser.
- If the external port is granted with ext_lock_i=1, go to EXT_LOCK with burst_cnt_q=1.

EXT_LOCK state:
- The core is blocked. The external port is granted whenever ext_req_i=1.
- burst_cnt_q increments every cycle, including idle cycles, and saturates at MAX_BURST.
- If ext_lock_i=0, return to ARB and clear burst_cnt_q. A request in that same cycle is still granted to the external port.
- If burst_cnt_q==MAX_BURST and core_req_i=1, grant the core, not the external port. Go to ARB, set prio_q=1, clear burst_cnt_q.
- If burst_cnt_q==MAX_BURST and core_req_i=0, stay in EXT_LOCK (saturated) with the external port still owning the memory.

Read return:
- rd_x_q <= x_gnt_o & ~x_we_i.
- x_rvalid_o = rd_x_q.
- x_rdata_o = mem_rdata_i when rd_x_q is set, otherwise 0.

Writes:
- A write is committed by the memory at the clock edge ending its grant cycle.
- Writes produce no rvalid.

## Timing
- Reset values:
  - state_q=ARB, prio_q=0, burst_cnt_q=0, rd_core_q=rd_ext_q=0.
  - All gnt/rvalid outputs are 0.
  - mem_en_o/mem_we_o are 0 while reset_i is high, regardless of requests.
- Grant latency: 0 cycles, same cycle as the request when it wins.
- Read data latency: exactly 1 cycle after the grant.
- Back-to-back grants, one per cycle, are allowed; a read granted in cycle N and another in cycle N+1 give rvalid in N+1 and N+2.
- A requester that is not granted keeps req high with fields stable; dropping req before grant is allowed and has no effect.
- Reset mid-operation discards outstanding rvalids and any lock immediately (asynchronous).
- Simultaneous ext_lock_i deassert and core request in EXT_LOCK: ext is granted if requesting, the core waits one cycle, and prio_q is left unchanged.

## Test plan
- Core only: read addr 0x10 (memory holds 0xDEADBEEF) -> core_gnt_o same cycle, core_rvalid_o next cycle with core_rdata_o=0xDEADBEEF, ext_rvalid_o=0.
- Tie with both held for 4 cycles after reset -> grants alternate core, ext, core, ext; mem_addr_o follows the winner each cycle.
- External write with lock held for 3 beats, core requesting throughout (MAX_BURST=8) -> 3 ext grants, lock released on beat 3, core granted on the next cycle.
- Lock held indefinitely with core requesting, MAX_BURST=4 -> ext granted for cycles 1-3, core granted on cycle 4 (burst_cnt_q=4), then ARB with prio_q=1.
- Core read granted, reset_i asserted before the next edge -> core_rvalid_o stays 0, all outputs 0, state ARB.
- Byte write: core_we_i=1, core_be_i=4'b0100, core_wdata_i=0x00AB0000 -> mem_be_o=4'b0100, mem_we_o=1 for one cycle, no rvalid.
